// File: rtl/dac_pkg.sv
// Shared constants and FSM state encoding for the DAC playback path.
// The DAC data register block imports the same constants.
package dac_pkg;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int DATA_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        PLAY  = 2'd3
    } state_t;

endpackage

// File: rtl/dac_playback_ctrl_if.sv
// Valid/ready sample stream from the IFFT core into the playback controller.
interface dac_playback_ctrl_if;
    import dac_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/dac_playback_ctrl.sv
// Loads one IFFT frame into the playback buffer, validates its length against
// s_last, and only enables looped playback of a complete frame.
module dac_playback_ctrl
    import dac_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_req,
    input  logic                   play_en,
    dac_playback_ctrl_if.slave     stream,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   data_en,
    output logic                   loaded,
    output logic                   frame_err,
    output logic [15:0]            frame_count
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] idx;
    logic              hs;
    logic              at_end;
    logic              start_load;
    logic              load_good;
    logic              load_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        hs         = stream.s_valid && stream.s_ready;
        at_end     = (idx == ADDR_W'(DEPTH - 1));
        start_load = 1'b0;
        load_good  = 1'b0;
        load_bad   = 1'b0;
        next_state = state;
        case (state)
            IDLE: begin
                if (load_req) begin
                    next_state = LOAD;
                    start_load = 1'b1;
                end else if (play_en && loaded) begin
                    next_state = PLAY;
                end
            end
            LOAD: begin
                if (hs) begin
                    if (at_end && stream.s_last) begin
                        load_good  = 1'b1;
                        next_state = play_en ? PLAY : IDLE;
                    end else if (at_end) begin
                        load_bad   = 1'b1;
                        next_state = DRAIN;
                    end else if (stream.s_last) begin
                        load_bad   = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (load_req) begin
                    next_state = LOAD;
                    start_load = 1'b1;
                end else if (hs && stream.s_last) begin
                    next_state = IDLE;
                end
            end
            PLAY: begin
                if (load_req) begin
                    next_state = LOAD;
                    start_load = 1'b1;
                end else if (!play_en) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // s_ready tracks next_state so it is already high in the first LOAD cycle;
    // idx may wrap after the final write but LOAD is always left at that point.
    always_ff @(posedge clk) begin
        if (reset) begin
            stream.s_ready <= 1'b0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            data_en        <= 1'b0;
            loaded         <= 1'b0;
            frame_err      <= 1'b0;
            frame_count    <= '0;
            idx            <= '0;
        end else begin
            stream.s_ready <= (next_state == LOAD) || (next_state == DRAIN);
            data_en        <= (state == PLAY);
            wr_en          <= hs && (state == LOAD);
            if (hs && (state == LOAD)) begin
                wr_addr <= idx;
                wr_data <= stream.s_data;
                idx     <= idx + ADDR_W'(1);
            end
            if (start_load) begin
                idx       <= '0;
                loaded    <= 1'b0;
                frame_err <= 1'b0;
            end
            if (load_good) begin
                loaded      <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end
            if (load_bad) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Directed bench for dac_playback_ctrl: good, short, long, reloaded, stalled
// and reset-interrupted frame loads with an independent write-port monitor.
module tb_dac_playback_ctrl;
    import dac_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_req;
    logic              play_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              data_en;
    logic              loaded;
    logic              frame_err;
    logic [15:0]       frame_count;

    int                n_cmp = 0;
    int                n_err = 0;
    int                wr_cnt = 0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] ofs = '0;

    dac_playback_ctrl_if bus ();

    dac_playback_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .load_req    (load_req),
        .play_en     (play_en),
        .stream      (bus),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .data_en     (data_en),
        .loaded      (loaded),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // Presents one sample and returns just after the edge that accepts it.
    task automatic push(input logic [DATA_W-1:0] d, input logic last, input bit stall);
        int guard;
        if (stall) begin
            bus.s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        guard = 0;
        while (bus.s_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) check_val("hs_timeout", 32'(bus.s_ready), 32'd1);
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic start_frame(input logic [DATA_W-1:0] new_ofs);
        ofs      = new_ofs;
        exp_addr = '0;
        wr_cnt   = 0;
        pulse_load();
    endtask

    // Every buffer write must land at the next contiguous address with its sample.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            check_val("wr_addr", 32'(wr_addr), 32'(exp_addr));
            check_val("wr_data", 32'(wr_data), 32'(DATA_W'(exp_addr) + ofs));
            exp_addr++;
            wr_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        load_req    = 1'b0;
        play_en     = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_val("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check_val("rst_wr_en", 32'(wr_en), 32'd0);
        check_val("rst_data_en", 32'(data_en), 32'd0);
        check_val("rst_loaded", 32'(loaded), 32'd0);
        check_val("rst_frame_err", 32'(frame_err), 32'd0);
        check_val("rst_frame_count", 32'(frame_count), 32'd0);

        $display("[TB] good frame with play enabled");
        play_en = 1'b1;
        start_frame(12'h000);
        check_val("good_s_ready_up", 32'(bus.s_ready), 32'd1);
        for (int i = 0; i < 256; i++) push(DATA_W'(i) + ofs, (i == 255), 1'b0);
        check_val("good_s_ready_down", 32'(bus.s_ready), 32'd0);
        check_val("good_loaded", 32'(loaded), 32'd1);
        check_val("good_count", 32'(frame_count), 32'd1);
        check_val("good_err", 32'(frame_err), 32'd0);
        check_val("good_data_en_n1", 32'(data_en), 32'd0);
        tick();
        check_val("good_data_en_n2", 32'(data_en), 32'd1);
        check_val("good_wr_cnt", 32'(wr_cnt), 32'd256);

        $display("[TB] reload during playback with stalled stream");
        start_frame(12'h100);
        check_val("reload_loaded_clr", 32'(loaded), 32'd0);
        tick();
        check_val("reload_data_en_off", 32'(data_en), 32'd0);
        for (int i = 0; i < 128; i++) push(DATA_W'(i) + ofs, 1'b0, 1'b1);
        check_val("reload_mid_data_en", 32'(data_en), 32'd0);
        check_val("reload_mid_loaded", 32'(loaded), 32'd0);
        for (int i = 128; i < 256; i++) push(DATA_W'(i) + ofs, (i == 255), 1'b1);
        check_val("reload_loaded", 32'(loaded), 32'd1);
        check_val("reload_count", 32'(frame_count), 32'd2);
        tick();
        check_val("reload_data_en_on", 32'(data_en), 32'd1);
        check_val("reload_wr_cnt", 32'(wr_cnt), 32'd256);

        play_en = 1'b0;
        repeat (2) tick();
        check_val("stop_data_en", 32'(data_en), 32'd0);
        check_val("stop_loaded", 32'(loaded), 32'd1);

        $display("[TB] short frame");
        play_en = 1'b1;
        start_frame(12'h200);
        for (int i = 0; i < 100; i++) push(DATA_W'(i) + ofs, (i == 99), 1'b0);
        check_val("short_err", 32'(frame_err), 32'd1);
        check_val("short_loaded", 32'(loaded), 32'd0);
        check_val("short_count", 32'(frame_count), 32'd2);
        check_val("short_s_ready", 32'(bus.s_ready), 32'd0);
        repeat (2) tick();
        check_val("short_data_en", 32'(data_en), 32'd0);
        check_val("short_wr_cnt", 32'(wr_cnt), 32'd100);

        $display("[TB] long frame");
        play_en = 1'b0;
        start_frame(12'h300);
        check_val("long_err_clr", 32'(frame_err), 32'd0);
        for (int i = 0; i < 300; i++) begin
            push(DATA_W'(i) + ofs, (i == 299), 1'b0);
            if (i == 255) begin
                check_val("long_drain_ready", 32'(bus.s_ready), 32'd1);
                check_val("long_drain_err", 32'(frame_err), 32'd1);
            end
        end
        check_val("long_s_ready", 32'(bus.s_ready), 32'd0);
        check_val("long_err", 32'(frame_err), 32'd1);
        check_val("long_loaded", 32'(loaded), 32'd0);
        check_val("long_count", 32'(frame_count), 32'd2);
        tick();
        check_val("long_wr_cnt", 32'(wr_cnt), 32'd256);

        $display("[TB] reset in the middle of a load");
        start_frame(12'h055);
        for (int i = 0; i < 50; i++) push(DATA_W'(i) + ofs, 1'b0, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = DATA_W'(50) + ofs;
        reset       = 1'b1;
        tick();
        check_val("mid_rst_s_ready", 32'(bus.s_ready), 32'd0);
        check_val("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check_val("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        check_val("mid_rst_wr_data", 32'(wr_data), 32'd0);
        check_val("mid_rst_data_en", 32'(data_en), 32'd0);
        check_val("mid_rst_loaded", 32'(loaded), 32'd0);
        check_val("mid_rst_count", 32'(frame_count), 32'd0);
        reset       = 1'b0;
        bus.s_valid = 1'b0;
        repeat (3) tick();
        check_val("mid_rst_wr_cnt", 32'(wr_cnt), 32'd50);
        check_val("mid_rst_idle_ready", 32'(bus.s_ready), 32'd0);

        $display("[TB] stalled good frame then late play enable");
        start_frame(12'h7F0);
        for (int i = 0; i < 256; i++) push(DATA_W'(i) + ofs, (i == 255), 1'b1);
        check_val("late_loaded", 32'(loaded), 32'd1);
        check_val("late_count", 32'(frame_count), 32'd1);
        repeat (2) tick();
        check_val("late_idle_data_en", 32'(data_en), 32'd0);
        check_val("late_wr_cnt", 32'(wr_cnt), 32'd256);
        play_en = 1'b1;
        tick();
        check_val("late_data_en_n1", 32'(data_en), 32'd0);
        tick();
        check_val("late_data_en_n2", 32'(data_en), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dac_playback_ctrl.md
# dac_playback_ctrl

Sequencer that owns the DAC waveform playback buffer. It accepts one IFFT output frame per load request over a valid/ready stream and writes it sample by sample into the 256-entry playback BRAM. It checks frame length against `s_last` and gates the buffer's read enable so the DAC loops only a complete, validated frame. It sits between the IFFT core and the DAC data register block; a host register drives the control inputs.

## Interface
- `DEPTH`, 256: samples per frame and playback buffer entries.
- `ADDR_W`, 8: buffer address width; must equal log2(`DEPTH`).
- `DATA_W`, 12: sample width, two's complement, passed through unchanged.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `load_req` in 1: single-cycle pulse that starts a frame load.
- `play_en` in 1: level input that permits looped playback.
- `s_valid` in 1: IFFT sample valid.
- `s_ready` out 1: controller accepts the sample.
- `s_data` in `DATA_W`: IFFT sample.
- `s_last` in 1: final sample of the IFFT frame.
- `wr_en` out 1: buffer write strobe.
- `wr_addr` out `ADDR_W`: buffer write address.
- `wr_data` out `DATA_W`: buffer write data.
- `data_en` out 1: buffer read enable for playback.
- `loaded` out 1: buffer holds a complete, validated frame.
- `frame_err` out 1: sticky flag; last load had a bad length.
- `frame_count` out 16: count of successful loads; wraps 0xFFFF→0.

## Operation
- FSM has four states: IDLE, LOAD, DRAIN, PLAY. Reset enters IDLE.
- **IDLE**
  - `s_ready`=0 and `data_en`=0.
  - `load_req` → LOAD. Entering LOAD sets the sample index to 0, clears `loaded` and clears `frame_err`.
  - If `play_en`=1 and `loaded`=1 → PLAY.
- **LOAD**
  - `s_ready`=1. Each handshake (`s_valid`&&`s_ready`) writes `s_data` at the current index, then increments the index.
  - Handshake at index `DEPTH`-1 with `s_last`=1: the load is good. Set `loaded`, increment `frame_count`, go to PLAY if `play_en`=1, else IDLE.
  - Handshake at index `DEPTH`-1 with `s_last`=0: set `frame_err` → DRAIN. The write at `DEPTH`-1 is still performed.
  - Handshake with `s_last`=1 at index < `DEPTH`-1: set `frame_err` → IDLE. That sample is written; `loaded` stays 0.
  - `load_req` while in LOAD is ignored.
- **DRAIN**
  - `s_ready`=1 and no writes are issued.
  - Handshake with `s_last`=1 → IDLE.
  - `load_req` → LOAD; this abandons the drain.
- **PLAY**
  - `data_en`=1.
  - `play_en`=0 → IDLE.
  - `load_req` → LOAD. Playback stops for the whole reload, so a partially updated frame is never played.
  - If both happen in the same cycle, `load_req` wins.
- Index counter is `ADDR_W` bits and never wraps inside LOAD; the transition to DRAIN prevents overflow.

## Timing
- All outputs are registered and reset to 0: `s_ready`, `wr_en`, `wr_addr`, `wr_data`, `data_en`, `loaded`, `frame_err`, `frame_count`.
- `s_ready` follows the state register. It goes high the cycle after `load_req` and low the cycle after the terminating handshake.
- Write latency is 1: a handshake in cycle N gives `wr_en`=1 with the matching `wr_addr`/`wr_data` in cycle N+1. `wr_en` is a one-cycle pulse per sample.
- The IFFT may present 1 sample per cycle. Back-to-back handshakes run at full throughput with no bubbles.
- `data_en` rises 1 cycle after the FSM enters PLAY and falls 1 cycle after it leaves PLAY.
- `loaded`, `frame_count` and `frame_err` update in the cycle after the terminating handshake.
- `reset` during LOAD: return to IDLE the next cycle and clear all outputs. No further `wr_en` is issued.

## Structure
- Shared package `dac_pkg` holds `DEPTH`, `ADDR_W`, `DATA_W` and the FSM state enum (IDLE/LOAD/DRAIN/PLAY). The DAC data register block imports the same constants.
- Single module with no sub-module. The FSM, index counter and write pipeline register are small enough to live inline.

## Test plan
- **Good frame:** `play_en`=1, pulse `load_req`, stream 256 samples 0..255 with `s_last` on the last one → 256 `wr_en` pulses at addresses 0..255 with data equal to address, `loaded`=1, `frame_count`=1, `data_en`=1 two cycles after the last handshake.
- **Short frame:** `s_last` on the 100th sample → writes at addresses 0..99, `frame_err`=1, `loaded`=0, `frame_count` unchanged, `data_en` stays 0.
- **Long frame:** 300 samples with `s_last` on the 300th → writes at addresses 0..255 only, `frame_err`=1, `s_ready` stays 1 until sample 300, then the FSM returns to IDLE.
- **Reload during PLAY:** `load_req` while playing → `data_en` drops 1 cycle later, `loaded`=0 until the new frame completes, then `data_en` reasserts.
- **Stalled stream:** `s_valid` toggled randomly across a full 256-sample frame → writes stay at contiguous addresses with no gaps or duplicates.
- **Reset mid-LOAD:** reset asserted at sample 50 → all outputs are 0 the next cycle and no further `wr_en` occurs.
